// File: rtl/bcd_counter_chain_pkg.sv
// Shared constants, mode encoding and digit helpers for the BCD counter chain.
package bcd_counter_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_MAX    = 2'd1,
        MODE_CARRY  = 2'd2
    } mode_t;

    // A nibble above 9 is not a legal BCD digit; read it as 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_counter_chain_if.sv
// Signal bundle between the mode selector / debouncers and the BCD counter.
// Handshake semantics: there is no valid/ready pair. cnt_up and cnt_down are
// level signals and each rising edge is one request; cnt_clear, carry_en,
// max_en and max_in are levels sampled on every clock; cnt_out is a level and
// wrap is a one-cycle pulse. mode exposes the registered counting mode.
interface bcd_counter_chain_if
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS = 6
);
    logic                  cnt_up;
    logic                  cnt_down;
    logic                  cnt_clear;
    logic [4*DIGITS-1:0]   max_in;
    logic                  carry_en;
    logic                  max_en;
    logic [4*DIGITS-1:0]   cnt_out;
    logic                  wrap;
    mode_t                 mode;

    modport master (
        output cnt_up, cnt_down, cnt_clear, max_in, carry_en, max_en,
        input  cnt_out, wrap, mode
    );

    modport slave (
        input  cnt_up, cnt_down, cnt_clear, max_in, carry_en, max_en,
        output cnt_out, wrap, mode
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit register. Priority: clear > load > inc > dec.
// o_carry / o_borrow flag that the digit sits at 9 / 0, i.e. an increment /
// decrement applied now would roll over and ripple to the next digit.
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_carry,
    output logic             o_borrow
);

    logic [BCD_W-1:0] r_digit;

    // Digit update; every path keeps the value inside 0..9.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_digit <= '0;
        end else if (i_load) begin
            r_digit <= bcd_clamp(i_load_val);
        end else if (i_inc) begin
            r_digit <= (r_digit >= BCD_MAX) ? '0 : r_digit + 4'd1;
        end else if (i_dec) begin
            r_digit <= (r_digit == '0) ? BCD_MAX : r_digit - 4'd1;
        end
    end

    assign o_digit  = r_digit;
    assign o_carry  = (r_digit == BCD_MAX);
    assign o_borrow = (r_digit == '0);

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up/down counter: edge detection of the request levels,
// registered mode, carry/borrow chain that skips disabled digits, and a
// BCD magnitude comparator with limit load for the max-value mode.
module bcd_counter_chain
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS = 6
)(
    input  logic                 clk,
    input  logic                 reset,
    bcd_counter_chain_if.slave   bus
);

    logic                  r_up_q;
    logic                  r_down_q;
    logic                  r_wrap;
    mode_t                 r_mode;

    logic [4*DIGITS-1:0]   w_cnt;
    logic [4*DIGITS-1:0]   w_lim;
    logic [DIGITS-1:0]     w_carry_flag;
    logic [DIGITS-1:0]     w_borrow_flag;
    logic [DIGITS-1:0]     w_en;
    logic [DIGITS-1:0]     w_inc;
    logic [DIGITS-1:0]     w_dec;
    logic [DIGITS-1:0]     w_clr;

    logic                  w_up_ev;
    logic                  w_down_ev;
    mode_t                 w_mode_next;
    logic                  w_mode_chg;
    logic                  w_cnt_en;
    logic                  w_count_up;
    logic                  w_count_dn;
    logic                  w_is_max;
    logic                  w_cnt_gt;
    logic                  w_cnt_eq;
    logic                  w_cnt_zero;
    logic                  w_max_wrap_up;
    logic                  w_load;
    logic                  w_chain_c;
    logic                  w_chain_b;
    logic                  w_wrap_next;

    assign w_up_ev     = bus.cnt_up & ~r_up_q;
    assign w_down_ev   = bus.cnt_down & ~r_down_q;
    assign w_mode_next = bus.carry_en ? MODE_CARRY : (bus.max_en ? MODE_MAX : MODE_SINGLE);
    assign w_mode_chg  = (w_mode_next != r_mode);
    // A clear or a mode change swallows any count event in the same cycle.
    assign w_cnt_en    = ~bus.cnt_clear & ~w_mode_chg;
    // Simultaneous up and down cancel out.
    assign w_count_up  = w_cnt_en & w_up_ev & ~w_down_ev;
    assign w_count_dn  = w_cnt_en & w_down_ev & ~w_up_ev;
    assign w_is_max    = (r_mode == MODE_MAX);
    assign w_cnt_zero  = (w_cnt == '0);

    // MAX mode: at/over the limit an up wraps to 0; at 0 or over the limit a down loads the limit.
    assign w_max_wrap_up = w_is_max & w_count_up & (w_cnt_gt | w_cnt_eq);
    assign w_load        = w_is_max & w_count_dn & (w_cnt_zero | w_cnt_gt);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            assign w_lim[4*g +: 4] = bcd_clamp(bus.max_in[4*g +: 4]);

            bcd_digit u_digit (
                .i_clk      (clk),
                .i_reset    (reset),
                .i_clear    (w_clr[g]),
                .i_load     (w_load),
                .i_load_val (w_lim[4*g +: 4]),
                .i_inc      (w_inc[g]),
                .i_dec      (w_dec[g]),
                .o_digit    (w_cnt[4*g +: 4]),
                .o_carry    (w_carry_flag[g]),
                .o_borrow   (w_borrow_flag[g])
            );
        end
    endgenerate

    // BCD magnitude compare of count against clamped limit, most significant digit first.
    always_comb begin
        w_cnt_gt = 1'b0;
        w_cnt_eq = 1'b1;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            if (w_cnt_eq) begin
                if (w_cnt[4*j +: 4] > w_lim[4*j +: 4]) begin
                    w_cnt_gt = 1'b1;
                    w_cnt_eq = 1'b0;
                end else if (w_cnt[4*j +: 4] < w_lim[4*j +: 4]) begin
                    w_cnt_eq = 1'b0;
                end
            end
        end
    end

    // Digit enables: digit 0 always; all digits in MAX; max_in[4j] selects digits in CARRY.
    always_comb begin
        w_en = '0;
        for (int j = 0; j < DIGITS; j++) begin
            w_en[j] = (j == 0) | w_is_max | ((r_mode == MODE_CARRY) & bus.max_in[4*j]);
        end
    end

    // Ripple carry/borrow through enabled digits; disabled digits pass it straight through.
    always_comb begin
        w_inc     = '0;
        w_dec     = '0;
        w_clr     = '0;
        w_chain_c = w_count_up & ~w_max_wrap_up;
        w_chain_b = w_count_dn & ~w_load;
        for (int j = 0; j < DIGITS; j++) begin
            w_inc[j] = w_en[j] & w_chain_c;
            w_dec[j] = w_en[j] & w_chain_b;
            w_clr[j] = bus.cnt_clear | w_mode_chg | ~w_en[j] | w_max_wrap_up;
            if (w_en[j]) begin
                w_chain_c = w_chain_c & w_carry_flag[j];
                w_chain_b = w_chain_b & w_borrow_flag[j];
            end
        end
        // Whatever leaves the top enabled digit is discarded and reported as a wrap.
        w_wrap_next = w_chain_c | w_chain_b | w_max_wrap_up | (w_load & w_cnt_zero);
    end

    // Request history, mode register and wrap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_up_q   <= 1'b1;
            r_down_q <= 1'b1;
            r_mode   <= MODE_SINGLE;
            r_wrap   <= 1'b0;
        end else begin
            r_up_q   <= bus.cnt_up;
            r_down_q <= bus.cnt_down;
            r_mode   <= w_mode_next;
            r_wrap   <= w_wrap_next;
        end
    end

    assign bus.cnt_out = w_cnt;
    assign bus.wrap    = r_wrap;
    assign bus.mode    = r_mode;

endmodule
